// File: rtl/raster_pkg.sv
// Shared types, screen geometry and small helpers for the triangle traversal engine.
// Optional build macro used by the engine: RASTER_SKIP_HIDDEN_EN.
package raster_pkg;

    localparam int W  = 640;
    localparam int H  = 480;
    localparam int XW = 10;
    localparam int YW = 9;
    localparam int DW = 20;
    localparam int EW = DW + 3;

    typedef logic signed [EW-1:0] edge_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP0 = 3'd1,
        ST_SETUP1 = 3'd2,
        ST_SCAN   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [XW-1:0] X_LAST     = XW'(W - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(H - 1);
    localparam edge_t         EDGE_ZERO  = {EW{1'b0}};
    localparam edge_t         AREA_LIMIT = edge_t'({1'b1, {DW{1'b0}}});

    function automatic edge_t ext_x(input logic [XW-1:0] v);
        return edge_t'({{(EW-XW){1'b0}}, v});
    endfunction

    function automatic edge_t ext_y(input logic [YW-1:0] v);
        return edge_t'({{(EW-YW){1'b0}}, v});
    endfunction

    function automatic logic [XW-1:0] min3_x(input logic [XW-1:0] p, input logic [XW-1:0] q,
                                             input logic [XW-1:0] r);
        logic [XW-1:0] m;
        m = (p < q) ? p : q;
        return (m < r) ? m : r;
    endfunction

    function automatic logic [XW-1:0] max3_x(input logic [XW-1:0] p, input logic [XW-1:0] q,
                                             input logic [XW-1:0] r);
        logic [XW-1:0] m;
        m = (p > q) ? p : q;
        return (m > r) ? m : r;
    endfunction

    function automatic logic [YW-1:0] min3_y(input logic [YW-1:0] p, input logic [YW-1:0] q,
                                             input logic [YW-1:0] r);
        logic [YW-1:0] m;
        m = (p < q) ? p : q;
        return (m < r) ? m : r;
    endfunction

    function automatic logic [YW-1:0] max3_y(input logic [YW-1:0] p, input logic [YW-1:0] q,
                                             input logic [YW-1:0] r);
        logic [YW-1:0] m;
        m = (p > q) ? p : q;
        return (m > r) ? m : r;
    endfunction

    // A pixel is covered when no edge function is negative (edges themselves count as inside).
    function automatic logic inside_edges(input edge_t e0, input edge_t e1, input edge_t e2);
        return ~e0[EW-1] & ~e1[EW-1] & ~e2[EW-1];
    endfunction

endpackage

// File: rtl/tri_setup_scan_edge_stepper.sv
// One incremental edge-function evaluator: holds the row-start value, the current value
// and the per-x / per-y increments, so the scan loop needs only adds and subtracts.
module edge_stepper
    import raster_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  step_x,
    input  logic  step_y,
    input  edge_t init_val,
    input  edge_t x_step,
    input  edge_t y_step,
    output edge_t cur_next
);

    edge_t row_q, row_d;
    edge_t cur_q, cur_d;
    edge_t xs_q,  xs_d;
    edge_t ys_q,  ys_d;

    // Next value: a new row restarts from the advanced row-start, a new column subtracts the x term.
    always_comb begin
        row_d = row_q;
        cur_d = cur_q;
        xs_d  = xs_q;
        ys_d  = ys_q;
        if (load) begin
            row_d = init_val;
            cur_d = init_val;
            xs_d  = x_step;
            ys_d  = y_step;
        end else if (step_y) begin
            row_d = row_q + ys_q;
            cur_d = row_q + ys_q;
        end else if (step_x) begin
            cur_d = cur_q - xs_q;
        end else begin
            cur_d = cur_q;
        end
    end

    // Edge state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= EDGE_ZERO;
            cur_q <= EDGE_ZERO;
            xs_q  <= EDGE_ZERO;
            ys_q  <= EDGE_ZERO;
        end else begin
            row_q <= row_d;
            cur_q <= cur_d;
            xs_q  <= xs_d;
            ys_q  <= ys_d;
        end
    end

    assign cur_next = cur_d;

endmodule

// File: rtl/tri_setup_scan.sv
// Triangle setup and bounding-box raster scan producing per-pixel coverage and edge weights.
// Build option RASTER_SKIP_HIDDEN_EN: only covered pixels are presented downstream.
module tri_setup_scan
    import raster_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          tri_valid,
    output logic          tri_ready,
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] x1,
    input  logic [XW-1:0] x2,
    input  logic [YW-1:0] y0,
    input  logic [YW-1:0] y1,
    input  logic [YW-1:0] y2,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic          visible,
    output logic [DW-1:0] ua,
    output logic [DW-1:0] va,
    output logic [DW-1:0] wa,
    output logic [DW-1:0] a,
    output logic          done
);

`ifdef RASTER_SKIP_HIDDEN_EN
    localparam logic SKIP_HIDDEN = 1'b1;
`else
    localparam logic SKIP_HIDDEN = 1'b0;
`endif

    state_t        state_q, state_d;
    logic          tri_ready_q, tri_ready_d;
    logic [XW-1:0] vx0_q, vx0_d, vx1_q, vx1_d, vx2_q, vx2_d;
    logic [YW-1:0] vy0_q, vy0_d, vy1_q, vy1_d, vy2_q, vy2_d;
    edge_t         dx0_q, dx0_d, dx1_q, dx1_d, dx2_q, dx2_d;
    edge_t         dy0_q, dy0_d, dy1_q, dy1_d, dy2_q, dy2_d;
    edge_t         area_q, area_d;
    logic [XW-1:0] xmin_q, xmin_d, xmax_q, xmax_d;
    logic [YW-1:0] ymin_q, ymin_d, ymax_q, ymax_d;
    logic [XW-1:0] px_q, px_d;
    logic [YW-1:0] py_q, py_d;
    logic          pix_valid_q, pix_valid_d;
    logic          visible_q, visible_d;
    logic [DW-1:0] ua_q, ua_d, va_q, va_d, wa_q, wa_d, a_q, a_d;
    logic          done_q, done_d;

    edge_t         ex0_s, ex1_s, ex2_s, ey0_s, ey1_s, ey2_s;
    edge_t         sdx0_s, sdx1_s, sdx2_s, sdy0_s, sdy1_s, sdy2_s, sarea_s;
    edge_t         exmin_s, eymin_s, init0_s, init1_s, init2_s;
    logic [XW-1:0] bxmin_s, bxmax_s, rxmin_s, rxmax_s;
    logic [YW-1:0] bymin_s, bymax_s, rymin_s, rymax_s;
    logic          load_s, step_x_s, step_y_s, rec_upd_s, end_scan_s, vis_s;
    edge_t         e0n_s, e1n_s, e2n_s;

    // Setup arithmetic: deltas, doubled signed area, clamped bbox and edge values at the bbox corner.
    always_comb begin
        ex0_s   = ext_x(vx0_q);
        ex1_s   = ext_x(vx1_q);
        ex2_s   = ext_x(vx2_q);
        ey0_s   = ext_y(vy0_q);
        ey1_s   = ext_y(vy1_q);
        ey2_s   = ext_y(vy2_q);
        sdx0_s  = ex2_s - ex1_s;
        sdy0_s  = ey2_s - ey1_s;
        sdx1_s  = ex0_s - ex2_s;
        sdy1_s  = ey0_s - ey2_s;
        sdx2_s  = ex1_s - ex0_s;
        sdy2_s  = ey1_s - ey0_s;
        sarea_s = (sdx2_s * (ey2_s - ey0_s)) - ((ex2_s - ex0_s) * sdy2_s);
        rxmin_s = min3_x(vx0_q, vx1_q, vx2_q);
        rxmax_s = max3_x(vx0_q, vx1_q, vx2_q);
        rymin_s = min3_y(vy0_q, vy1_q, vy2_q);
        rymax_s = max3_y(vy0_q, vy1_q, vy2_q);
        bxmin_s = (rxmin_s > X_LAST) ? X_LAST : rxmin_s;
        bxmax_s = (rxmax_s > X_LAST) ? X_LAST : rxmax_s;
        bymin_s = (rymin_s > Y_LAST) ? Y_LAST : rymin_s;
        bymax_s = (rymax_s > Y_LAST) ? Y_LAST : rymax_s;
        exmin_s = ext_x(xmin_q);
        eymin_s = ext_y(ymin_q);
        init0_s = (dx0_q * (eymin_s - ey1_s)) - (dy0_q * (exmin_s - ex1_s));
        init1_s = (dx1_q * (eymin_s - ey2_s)) - (dy1_q * (exmin_s - ex2_s));
        init2_s = (dx2_q * (eymin_s - ey0_s)) - (dy2_q * (exmin_s - ex0_s));
    end

    // Control FSM: next state, latched setup values, scan position and stepper commands.
    always_comb begin
        state_d    = state_q;
        vx0_d      = vx0_q;
        vx1_d      = vx1_q;
        vx2_d      = vx2_q;
        vy0_d      = vy0_q;
        vy1_d      = vy1_q;
        vy2_d      = vy2_q;
        dx0_d      = dx0_q;
        dx1_d      = dx1_q;
        dx2_d      = dx2_q;
        dy0_d      = dy0_q;
        dy1_d      = dy1_q;
        dy2_d      = dy2_q;
        area_d     = area_q;
        xmin_d     = xmin_q;
        xmax_d     = xmax_q;
        ymin_d     = ymin_q;
        ymax_d     = ymax_q;
        px_d       = px_q;
        py_d       = py_q;
        a_d        = a_q;
        load_s     = 1'b0;
        step_x_s   = 1'b0;
        step_y_s   = 1'b0;
        rec_upd_s  = 1'b0;
        end_scan_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tri_valid) begin
                    vx0_d   = x0;
                    vx1_d   = x1;
                    vx2_d   = x2;
                    vy0_d   = y0;
                    vy1_d   = y1;
                    vy2_d   = y2;
                    state_d = ST_SETUP0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP0: begin
                dx0_d   = sdx0_s;
                dx1_d   = sdx1_s;
                dx2_d   = sdx2_s;
                dy0_d   = sdy0_s;
                dy1_d   = sdy1_s;
                dy2_d   = sdy2_s;
                area_d  = sarea_s;
                xmin_d  = bxmin_s;
                xmax_d  = bxmax_s;
                ymin_d  = bymin_s;
                ymax_d  = bymax_s;
                state_d = ST_SETUP1;
            end
            ST_SETUP1: begin
                // Back-facing, degenerate or unrepresentable triangles produce no pixels.
                if ((area_q <= EDGE_ZERO) || (area_q >= AREA_LIMIT)) begin
                    state_d = ST_DONE;
                end else begin
                    load_s    = 1'b1;
                    rec_upd_s = 1'b1;
                    px_d      = xmin_q;
                    py_d      = ymin_q;
                    a_d       = area_q[DW-1:0];
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!pix_valid_q || pix_ready) begin
                    if ((px_q == xmax_q) && (py_q == ymax_q)) begin
                        end_scan_s = 1'b1;
                        state_d    = ST_DONE;
                    end else if (px_q == xmax_q) begin
                        step_y_s  = 1'b1;
                        rec_upd_s = 1'b1;
                        px_d      = xmin_q;
                        py_d      = py_q + YW'(1);
                    end else begin
                        step_x_s  = 1'b1;
                        rec_upd_s = 1'b1;
                        px_d      = px_q + XW'(1);
                    end
                end else begin
                    state_d = ST_SCAN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        tri_ready_d = (state_d == ST_IDLE);
        done_d      = (state_q == ST_DONE);
    end

    edge_stepper u_edge0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_s),
        .step_x   (step_x_s),
        .step_y   (step_y_s),
        .init_val (init0_s),
        .x_step   (dy0_q),
        .y_step   (dx0_q),
        .cur_next (e0n_s)
    );

    edge_stepper u_edge1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_s),
        .step_x   (step_x_s),
        .step_y   (step_y_s),
        .init_val (init1_s),
        .x_step   (dy1_q),
        .y_step   (dx1_q),
        .cur_next (e1n_s)
    );

    edge_stepper u_edge2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load_s),
        .step_x   (step_x_s),
        .step_y   (step_y_s),
        .init_val (init2_s),
        .x_step   (dy2_q),
        .y_step   (dx2_q),
        .cur_next (e2n_s)
    );

    // Output record: rebuilt whenever the scan position moves, otherwise held for backpressure.
    always_comb begin
        pix_valid_d = pix_valid_q;
        visible_d   = visible_q;
        ua_d        = ua_q;
        va_d        = va_q;
        wa_d        = wa_q;
        vis_s       = inside_edges(e0n_s, e1n_s, e2n_s);
        if (rec_upd_s) begin
            visible_d   = vis_s;
            ua_d        = vis_s ? e0n_s[DW-1:0] : {DW{1'b0}};
            va_d        = vis_s ? e1n_s[DW-1:0] : {DW{1'b0}};
            wa_d        = vis_s ? e2n_s[DW-1:0] : {DW{1'b0}};
            pix_valid_d = vis_s | ~SKIP_HIDDEN;
        end else if (end_scan_s) begin
            pix_valid_d = 1'b0;
        end else begin
            pix_valid_d = pix_valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tri_ready_q <= 1'b1;
            vx0_q       <= {XW{1'b0}};
            vx1_q       <= {XW{1'b0}};
            vx2_q       <= {XW{1'b0}};
            vy0_q       <= {YW{1'b0}};
            vy1_q       <= {YW{1'b0}};
            vy2_q       <= {YW{1'b0}};
            dx0_q       <= EDGE_ZERO;
            dx1_q       <= EDGE_ZERO;
            dx2_q       <= EDGE_ZERO;
            dy0_q       <= EDGE_ZERO;
            dy1_q       <= EDGE_ZERO;
            dy2_q       <= EDGE_ZERO;
            area_q      <= EDGE_ZERO;
            xmin_q      <= {XW{1'b0}};
            xmax_q      <= {XW{1'b0}};
            ymin_q      <= {YW{1'b0}};
            ymax_q      <= {YW{1'b0}};
            px_q        <= {XW{1'b0}};
            py_q        <= {YW{1'b0}};
            pix_valid_q <= 1'b0;
            visible_q   <= 1'b0;
            ua_q        <= {DW{1'b0}};
            va_q        <= {DW{1'b0}};
            wa_q        <= {DW{1'b0}};
            a_q         <= {DW{1'b0}};
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            tri_ready_q <= tri_ready_d;
            vx0_q       <= vx0_d;
            vx1_q       <= vx1_d;
            vx2_q       <= vx2_d;
            vy0_q       <= vy0_d;
            vy1_q       <= vy1_d;
            vy2_q       <= vy2_d;
            dx0_q       <= dx0_d;
            dx1_q       <= dx1_d;
            dx2_q       <= dx2_d;
            dy0_q       <= dy0_d;
            dy1_q       <= dy1_d;
            dy2_q       <= dy2_d;
            area_q      <= area_d;
            xmin_q      <= xmin_d;
            xmax_q      <= xmax_d;
            ymin_q      <= ymin_d;
            ymax_q      <= ymax_d;
            px_q        <= px_d;
            py_q        <= py_d;
            pix_valid_q <= pix_valid_d;
            visible_q   <= visible_d;
            ua_q        <= ua_d;
            va_q        <= va_d;
            wa_q        <= wa_d;
            a_q         <= a_d;
            done_q      <= done_d;
        end
    end

    assign tri_ready = tri_ready_q;
    assign pix_valid = pix_valid_q;
    assign pix_x     = px_q;
    assign pix_y     = py_q;
    assign visible   = visible_q;
    assign ua        = ua_q;
    assign va        = va_q;
    assign wa        = wa_q;
    assign a         = a_q;
    assign done      = done_q;

endmodule

// File: tb/tb_tri_setup_scan.sv
// Randomized self-checking bench for tri_setup_scan against a direct edge-function pixel model.
module tb_tri_setup_scan;
    import raster_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          tri_valid = 1'b0;
    logic          pix_ready = 1'b0;
    logic [XW-1:0] x0 = '0, x1 = '0, x2 = '0;
    logic [YW-1:0] y0 = '0, y1 = '0, y2 = '0;
    logic          tri_ready, pix_valid, visible, done;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
    logic [DW-1:0] ua, va, wa, a;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        int px;
        int py;
        bit vis;
        int ua;
        int va;
        int wa;
    } rec_t;

    rec_t exp_q[$];
    int   m_area, m_npix, m_first_k, rec_cnt, vis_cnt, max_px;

    tri_setup_scan dut (
        .clk(clk), .rst_n(rst_n), .tri_valid(tri_valid), .tri_ready(tri_ready),
        .x0(x0), .x1(x1), .x2(x2), .y0(y0), .y1(y1), .y2(y2),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
        .visible(visible), .ua(ua), .va(va), .wa(wa), .a(a), .done(done)
    );

    always #5 clk = ~clk;

    // Reference: evaluate every bbox pixel directly from the edge-function definitions.
    task automatic build_model(input int ax0, input int ay0, input int ax1, input int ay1,
                               input int ax2, input int ay2);
        int xlo, xhi, ylo, yhi, idx, e0, e1, e2, first;
        bit vis;
        rec_t r;
        exp_q.delete();
        m_area = (ax1 - ax0) * (ay2 - ay0) - (ax2 - ax0) * (ay1 - ay0);
        m_npix = 0;
        m_first_k = -1;
        if (m_area <= 0 || m_area >= (1 << DW)) return;
        xlo = (ax0 < ax1) ? ax0 : ax1; xlo = (xlo < ax2) ? xlo : ax2;
        xhi = (ax0 > ax1) ? ax0 : ax1; xhi = (xhi > ax2) ? xhi : ax2;
        ylo = (ay0 < ay1) ? ay0 : ay1; ylo = (ylo < ay2) ? ylo : ay2;
        yhi = (ay0 > ay1) ? ay0 : ay1; yhi = (yhi > ay2) ? yhi : ay2;
        if (xlo > W - 1) xlo = W - 1;
        if (xhi > W - 1) xhi = W - 1;
        if (ylo > H - 1) ylo = H - 1;
        if (yhi > H - 1) yhi = H - 1;
        idx = 0;
        first = -1;
        for (int py = ylo; py <= yhi; py++) begin
            for (int px = xlo; px <= xhi; px++) begin
                e0 = (ax2 - ax1) * (py - ay1) - (ay2 - ay1) * (px - ax1);
                e1 = (ax0 - ax2) * (py - ay2) - (ay0 - ay2) * (px - ax2);
                e2 = (ax1 - ax0) * (py - ay0) - (ay1 - ay0) * (px - ax0);
                vis = (e0 >= 0) && (e1 >= 0) && (e2 >= 0);
                r.px = px; r.py = py; r.vis = vis;
                r.ua = vis ? e0 : 0; r.va = vis ? e1 : 0; r.wa = vis ? e2 : 0;
                if (vis && first < 0) first = idx;
`ifdef RASTER_SKIP_HIDDEN_EN
                if (vis) exp_q.push_back(r);
`else
                exp_q.push_back(r);
`endif
                idx++;
            end
        end
        m_npix = idx;
`ifdef RASTER_SKIP_HIDDEN_EN
        m_first_k = 3 + first;
`else
        m_first_k = 3;
`endif
    endtask

    // Offer one triangle and consume its pixel stream, checking every record and the done pulse.
    task automatic run_scan(input int ax0, input int ay0, input int ax1, input int ay1,
                            input int ax2, input int ay2, input bit rnd_ready, input bit poke_tv);
        int k, budget;
        bit got_done, stalled, seen_first;
        logic [XW+YW+4*DW:0] snap, cur, expv;
        rec_t e;
        build_model(ax0, ay0, ax1, ay1, ax2, ay2);
        budget = 20 * m_npix + 40;
        rec_cnt = 0; vis_cnt = 0; max_px = 0;
        @(negedge clk);
        tests_run++;
        if (tri_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL accept_ready got=%b exp=1", tri_ready);
        end
        x0 = XW'(ax0); x1 = XW'(ax1); x2 = XW'(ax2);
        y0 = YW'(ay0); y1 = YW'(ay1); y2 = YW'(ay2);
        tri_valid = 1'b1;
        pix_ready = 1'b0;
        @(negedge clk);
        tri_valid = 1'b0;
        k = 1; got_done = 0; stalled = 0; seen_first = 0; snap = '0;
        while (k <= budget && !got_done) begin
            if (poke_tv) begin
                if (k >= 2 && k <= 4) begin
                    tri_valid = 1'b1;
                    x0 = XW'($urandom); y1 = YW'($urandom);
                    tests_run++;
                    if (tri_ready !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL busy_ready k=%0d got=%b exp=0", k, tri_ready);
                    end
                end else begin
                    tri_valid = 1'b0;
                end
            end
            pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            cur = {pix_x, pix_y, visible, ua, va, wa, a};
            if (stalled) begin
                tests_run++;
                if (cur !== snap || pix_valid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL stall_hold k=%0d got=%h/%b exp=%h/1", k, cur, pix_valid, snap);
                end
            end
            stalled = 0;
            if (pix_valid === 1'b1) begin
                if (!seen_first) begin
                    seen_first = 1;
                    tests_run++;
                    if (k != m_first_k) begin
                        tests_failed++;
                        $display("FAIL first_latency got=%0d exp=%0d", k, m_first_k);
                    end
                end
                if (pix_ready) begin
                    rec_cnt++;
                    if (int'(pix_x) > max_px) max_px = int'(pix_x);
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        tests_failed++;
                        $display("FAIL extra_record at (%0d,%0d)", pix_x, pix_y);
                    end else begin
                        e = exp_q.pop_front();
                        expv = {XW'(e.px), YW'(e.py), e.vis, DW'(e.ua), DW'(e.va), DW'(e.wa), DW'(m_area)};
                        if (cur !== expv) begin
                            tests_failed++;
                            $display("FAIL record got x=%0d y=%0d vis=%b u=%0d v=%0d w=%0d a=%0d exp x=%0d y=%0d vis=%b u=%0d v=%0d w=%0d a=%0d",
                                     pix_x, pix_y, visible, ua, va, wa, a, e.px, e.py, e.vis, e.ua, e.va, e.wa, m_area);
                        end
                        if (visible === 1'b1) begin
                            vis_cnt++;
                            tests_run++;
                            if (ua + va + wa !== a) begin
                                tests_failed++;
                                $display("FAIL weight_sum got=%0d exp=%0d", ua + va + wa, a);
                            end
                        end
                    end
                end else begin
                    stalled = 1;
                    snap = cur;
                end
            end
            if (done === 1'b1) begin
                got_done = 1;
                tests_run++;
                if (exp_q.size() != 0 || pix_valid !== 1'b0 || tri_ready !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL done_state left=%0d pv=%b rdy=%b exp 0/0/1", exp_q.size(), pix_valid, tri_ready);
                end
                if (!rnd_ready) begin
                    tests_run++;
                    if (k != m_npix + 4) begin
                        tests_failed++;
                        $display("FAIL done_latency got=%0d exp=%0d", k, m_npix + 4);
                    end
                end
            end
            @(negedge clk);
            k++;
        end
        tri_valid = 1'b0;
        tests_run++;
        if (!got_done) begin
            tests_failed++;
            $display("FAIL done_timeout got=none exp=pulse within %0d cycles", budget);
        end else if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL done_width got=%b exp=0", done);
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if ({tri_ready, pix_valid, done, pix_x, pix_y, visible, ua, va, wa, a} !==
            {1'b1, 1'b0, 1'b0, {XW{1'b0}}, {YW{1'b0}}, 1'b0, {(4*DW){1'b0}}}) begin
            tests_failed++;
            $display("FAIL reset_values got rdy=%b pv=%b done=%b x=%0d y=%0d a=%0d exp 1/0/0/0/0/0",
                     tri_ready, pix_valid, done, pix_x, pix_y, a);
        end
    endtask

    task automatic test_basic();
        run_scan(0, 0, 4, 0, 0, 4, 1'b0, 1'b0);
        tests_run++;
`ifdef RASTER_SKIP_HIDDEN_EN
        if (rec_cnt != 15 || vis_cnt != 15) begin
`else
        if (rec_cnt != 25 || vis_cnt != 15) begin
`endif
            tests_failed++;
            $display("FAIL basic_counts got rec=%0d vis=%0d", rec_cnt, vis_cnt);
        end
    endtask

    task automatic test_backface();
        run_scan(0, 0, 0, 4, 4, 0, 1'b0, 1'b0);
        tests_run++;
        if (rec_cnt != 0) begin
            tests_failed++;
            $display("FAIL backface_records got=%0d exp=0", rec_cnt);
        end
    endtask

    task automatic test_back_pressure();
        run_scan(0, 0, 4, 0, 0, 4, 1'b1, 1'b1);
        tests_run++;
        if (vis_cnt != 15) begin
            tests_failed++;
            $display("FAIL stall_vis_count got=%0d exp=15", vis_cnt);
        end
    endtask

    task automatic test_clamp();
        run_scan(0, 0, 1000, 0, 0, 3, 1'b0, 1'b0);
        tests_run++;
        if (max_px != W - 1) begin
            tests_failed++;
            $display("FAIL clamp_max_x got=%0d exp=%0d", max_px, W - 1);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        x0 = '0; y0 = '0; x1 = XW'(4); y1 = '0; x2 = '0; y2 = YW'(4);
        tri_valid = 1'b1;
        pix_ready = 1'b1;
        @(negedge clk);
        tri_valid = 1'b0;
        repeat (6) @(negedge clk);
        tests_run++;
        if (pix_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_scan_active got=%b exp=1", pix_valid);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            tests_run++;
            if (done !== 1'b0 || pix_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL post_reset_quiet got done=%b pv=%b exp 0/0", done, pix_valid);
            end
        end
        run_scan(2, 1, 9, 3, 4, 8, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        int bx, by;
        for (int t = 0; t < 8; t++) begin
            bx = (t == 3) ? 1005 : int'($urandom_range(0, 1010));
            by = int'($urandom_range(0, 498));
            run_scan(bx + int'($urandom_range(0, 12)), by + int'($urandom_range(0, 12)),
                     bx + int'($urandom_range(0, 12)), by + int'($urandom_range(0, 12)),
                     bx + int'($urandom_range(0, 12)), by + int'($urandom_range(0, 12)),
                     1'(t % 2), 1'b0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_backface();
        test_back_pressure();
        test_clamp();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
